// File: rtl/fsm_sched_pkg.sv
// Shared types and constants for the round-robin pulse-detector scheduler.
package fsm_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLR  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } sched_state_t;

  localparam int STAT_W = 16;

  // Saturating increment used by the optional event counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/fsm_pulse_sched_rr_arbiter.sv
// Round-robin pick: first requester at or after rr_ptr, wrapping to the
// lowest index. Purely combinational; the scheduler owns the pointer.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   rr_ptr,
  output logic [N_REQ-1:0] pick,
  output logic [IDW-1:0]   pick_id,
  output logic             any
);

  // Two passes: indices at/after the pointer first, then wrap to the lowest.
  always_comb begin
    pick    = '0;
    pick_id = '0;
    any     = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!any && req[i] && (i >= int'(rr_ptr))) begin
        any     = 1'b1;
        pick[i] = 1'b1;
        pick_id = IDW'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!any && req[i]) begin
        any     = 1'b1;
        pick[i] = 1'b1;
        pick_id = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/fsm_pulse_sched.sv
// Time-shares one Moore pulse detector among N_REQ requesters.
// Each grant: clear the detector (S_CLR), steer the granted serial bit into
// it (S_RUN) until a full high->low pulse is seen, the requester drops req
// (abort) or the grant expires (timeout).
// Handshake: a requester holds req high until it sees done/timeout for its
// id, or drops req to abandon the grant; gnt is one-hot while its bit is
// being steered to the detector.
// Optional build macro FSM_SCHED_STATS_EN adds saturating done_cnt and
// timeout_cnt outputs.
module fsm_pulse_sched
  import fsm_sched_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 16,
  parameter int IDW         = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] req_bit,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [IDW-1:0]   done_id,
  output logic             det_resetn,
  output logic             det_in,
  input  logic             det_out,
  output logic [1:0]       dbg_state
`ifdef FSM_SCHED_STATS_EN
  ,
  output logic [STAT_W-1:0] done_cnt,
  output logic [STAT_W-1:0] timeout_cnt
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYC);

  sched_state_t     state, next_state;
  logic [IDW-1:0]   cur_id, rr_ptr;
  logic [N_REQ-1:0] cur_oh;
  logic [TW-1:0]    timer;
  logic             seen_hi;
  logic             det_resetn_q, timeout_q;

  logic [N_REQ-1:0] arb_pick;
  logic [IDW-1:0]   arb_id;
  logic             arb_any;
  logic             complete, abort_req, expire;

  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] id);
    return (int'(id) == N_REQ - 1) ? '0 : id + IDW'(1);
  endfunction

  rr_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr),
    .pick   (arb_pick),
    .pick_id(arb_id),
    .any    (arb_any)
  );

  assign complete  = seen_hi && !det_out;
  assign abort_req = !req[cur_id];
  assign expire    = (timer == TW'(TIMEOUT_CYC - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic; completion outranks abort, abort outranks timeout.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (arb_any) next_state = S_CLR;
      S_CLR:  next_state = S_RUN;
      S_RUN: begin
        if (complete)                 next_state = S_DONE;
        else if (abort_req || expire) next_state = S_IDLE;
      end
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Moore outputs decoded from registered state; det_in muxes the live bit.
  always_comb begin
    gnt    = '0;
    det_in = 1'b0;
    busy   = (state != S_IDLE);
    done   = (state == S_DONE);
    if (state == S_CLR || state == S_RUN) gnt = cur_oh;
    if (state == S_RUN) det_in = req_bit[cur_id];
  end

  // Grant bookkeeping: owner, pointer, timer, pulse tracking, event id.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_id       <= '0;
      cur_oh       <= '0;
      rr_ptr       <= '0;
      done_id      <= '0;
      timer        <= '0;
      seen_hi      <= 1'b0;
      det_resetn_q <= 1'b1;
      timeout_q    <= 1'b0;
    end else begin
      det_resetn_q <= !(next_state == S_CLR);
      timeout_q    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (arb_any) begin
            cur_id <= arb_id;
            cur_oh <= arb_pick;
          end
        end
        S_CLR: begin
          timer   <= '0;
          seen_hi <= 1'b0;
        end
        S_RUN: begin
          timer <= timer + TW'(1);
          if (det_out) seen_hi <= 1'b1;
          if (complete) begin
            done_id <= cur_id;
          end else if (abort_req) begin
            rr_ptr <= wrap_inc(cur_id);
          end else if (expire) begin
            timeout_q <= 1'b1;
            done_id   <= cur_id;
            rr_ptr    <= wrap_inc(cur_id);
          end
        end
        S_DONE: rr_ptr <= wrap_inc(cur_id);
        default: ;
      endcase
    end
  end

  assign det_resetn = det_resetn_q;
  assign timeout    = timeout_q;
  assign dbg_state  = state;

`ifdef FSM_SCHED_STATS_EN
  // Saturating event counters, bumped during each done/timeout pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_cnt    <= '0;
      timeout_cnt <= '0;
    end else begin
      if (done)    done_cnt    <= sat_inc(done_cnt);
      if (timeout) timeout_cnt <= sat_inc(timeout_cnt);
    end
  end
`else
`endif

endmodule
